// File: rtl/fir_filter_stm.sv
// Control and datapath front end for a stereo FIR filter: tap delay line,
// coefficient read sequencing, signed products and accumulator strobes.
module fir_filter_stm #(
  parameter int NTAPS  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              filter_aud_in_rts,
  output logic              filter_aud_in_rtr,
  input  logic [31:0]       filter_aud_in,
  output logic              filter_aud_out_rts,
  input  logic              filter_aud_out_rtr,
  output logic              accumulator_load,
  output logic              accumulator_enable,
  output logic [31:0]       accumulator_in_left,
  output logic [31:0]       accumulator_in_right,
  input  logic [15:0]       rf_filter_coeff,
  output logic              mux_re,
  output logic [ADDR_W-1:0] mux_rdptr
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_MAC   = 2'd2;
  localparam logic [1:0] S_OUT   = 2'd3;

  localparam logic [ADDR_W-1:0] K_LAST = ADDR_W'(NTAPS - 1);

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_k;
  logic [31:0]       r_x [NTAPS];

  // NOTE: the delay line is an array of flops rather than a RAM, so it can and
  // must be cleared by reset; a stale history would leak into the next output.
  always_ff @(posedge clk) begin
    if (rstb) begin
      r_state <= S_IDLE;
      r_k     <= '0;
      for (int i = 0; i < NTAPS; i++) r_x[i] <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (filter_aud_in_rts) begin
            for (int i = NTAPS - 1; i > 0; i--) r_x[i] <= r_x[i-1];
            r_x[0]  <= filter_aud_in;
            r_state <= S_FETCH;
          end
        end
        S_FETCH: begin
          r_k     <= '0;
          r_state <= S_MAC;
        end
        S_MAC: begin
          if (r_k == K_LAST) r_state <= S_OUT;
          else               r_k     <= r_k + 1'b1;
        end
        S_OUT: begin
          if (filter_aud_out_rtr) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  logic w_idle, w_fetch, w_mac, w_out, w_last;
  assign w_idle  = (r_state == S_IDLE);
  assign w_fetch = (r_state == S_FETCH);
  assign w_mac   = (r_state == S_MAC);
  assign w_out   = (r_state == S_OUT);
  assign w_last  = (r_k == K_LAST);

  assign filter_aud_in_rtr  = w_idle;
  assign filter_aud_out_rts = w_out;
  assign accumulator_load   = w_mac & (r_k == '0);
  assign accumulator_enable = w_mac & (r_k != '0);

  // Coefficient reads run one tap ahead: the value requested now arrives next cycle.
  assign mux_re    = w_fetch | (w_mac & ~w_last);
  assign mux_rdptr = (w_mac & ~w_last) ? r_k + 1'b1 : '0;

  logic [31:0]        w_x_sel;
  logic signed [31:0] w_xl, w_xr, w_c, w_prod_l, w_prod_r;
  assign w_x_sel  = r_x[r_k];
  assign w_xl     = {{16{w_x_sel[31]}}, w_x_sel[31:16]};
  assign w_xr     = {{16{w_x_sel[15]}}, w_x_sel[15:0]};
  assign w_c      = {{16{rf_filter_coeff[15]}}, rf_filter_coeff};
  assign w_prod_l = w_xl * w_c;
  assign w_prod_r = w_xr * w_c;

  assign accumulator_in_left  = w_mac ? w_prod_l : '0;
  assign accumulator_in_right = w_mac ? w_prod_r : '0;

endmodule

// File: tb/tb_fir_filter_stm.sv
// Directed self-checking bench for fir_filter_stm with a one-cycle-latency
// coefficient register-file model.
module tb_fir_filter_stm;

  localparam int NTAPS  = 16;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rstb;
  logic              filter_aud_in_rts;
  logic              filter_aud_in_rtr;
  logic [31:0]       filter_aud_in;
  logic              filter_aud_out_rts;
  logic              filter_aud_out_rtr;
  logic              accumulator_load;
  logic              accumulator_enable;
  logic [31:0]       accumulator_in_left;
  logic [31:0]       accumulator_in_right;
  logic [15:0]       rf_filter_coeff = 16'h0;
  logic              mux_re;
  logic [ADDR_W-1:0] mux_rdptr;

  fir_filter_stm #(.NTAPS(NTAPS), .ADDR_W(ADDR_W)) dut (
    .clk                  (clk),
    .rstb                 (rstb),
    .filter_aud_in_rts    (filter_aud_in_rts),
    .filter_aud_in_rtr    (filter_aud_in_rtr),
    .filter_aud_in        (filter_aud_in),
    .filter_aud_out_rts   (filter_aud_out_rts),
    .filter_aud_out_rtr   (filter_aud_out_rtr),
    .accumulator_load     (accumulator_load),
    .accumulator_enable   (accumulator_enable),
    .accumulator_in_left  (accumulator_in_left),
    .accumulator_in_right (accumulator_in_right),
    .rf_filter_coeff      (rf_filter_coeff),
    .mux_re               (mux_re),
    .mux_rdptr            (mux_rdptr)
  );

  always #5 clk = ~clk;

  logic [15:0] coef_tab [NTAPS];

  // Register file: data for a read request appears the following cycle.
  always @(posedge clk) rf_filter_coeff <= mux_re ? coef_tab[mux_rdptr] : 16'h0;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] cap_l [NTAPS];
  logic [31:0] cap_r [NTAPS];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Entered one cycle after the transfer edge (FETCH); leaves with OUT observed,
  // which is 18 edges after the transfer edge.
  task automatic run_mac();
    int n_load;
    int n_en;
    n_load = 0;
    n_en   = 0;
    check("fetch_re",  mux_re, 1'b1);
    check("fetch_ptr", mux_rdptr, 0);
    check("fetch_rtr", filter_aud_in_rtr, 1'b0);
    for (int k = 0; k < NTAPS; k++) begin
      cyc();
      cap_l[k] = accumulator_in_left;
      cap_r[k] = accumulator_in_right;
      if (accumulator_load) n_load++;
      if (accumulator_enable) n_en++;
      check($sformatf("mac%0d_load", k), accumulator_load, (k == 0) ? 1 : 0);
      check($sformatf("mac%0d_en", k), accumulator_enable, (k != 0) ? 1 : 0);
      check($sformatf("mac%0d_re", k), mux_re, (k < NTAPS - 1) ? 1 : 0);
      check($sformatf("mac%0d_ptr", k), mux_rdptr, (k < NTAPS - 1) ? k + 1 : 0);
      check($sformatf("mac%0d_ortsl", k), filter_aud_out_rts, 1'b0);
    end
    check("load_count", n_load, 1);
    check("en_count",   n_en,   NTAPS - 1);
    cyc();
    check("out_rts_rise", filter_aud_out_rts, 1'b1);
    check("out_in_rtr",   filter_aud_in_rtr,  1'b0);
    check("out_strobes",  {accumulator_load, accumulator_enable, mux_re}, 0);
    check("out_acc_l",    accumulator_in_left, 0);
  endtask

  task automatic send(input logic [31:0] d);
    filter_aud_in_rts = 1'b1;
    filter_aud_in     = d;
    check("idle_rtr", filter_aud_in_rtr, 1'b1);
    cyc();
    filter_aud_in_rts = 1'b0;
    run_mac();
  endtask

  task automatic finish_out();
    filter_aud_out_rtr = 1'b1;
    cyc();
    check("back_idle_rts", filter_aud_out_rts, 1'b0);
    check("back_idle_rtr", filter_aud_in_rtr,  1'b1);
  endtask

  task automatic check_impulse(input int n, input string pfx);
    for (int k = 0; k < NTAPS; k++) begin
      int e;
      e = (k == n) ? n + 1 : 0;
      check($sformatf("%s%0d_l%0d", pfx, n, k), cap_l[k], e);
      check($sformatf("%s%0d_r%0d", pfx, n, k), cap_r[k], -e);
    end
  endtask

  initial begin
    for (int k = 0; k < NTAPS; k++) coef_tab[k] = 16'(k + 1);
    rstb               = 1'b1;
    filter_aud_in_rts  = 1'b0;
    filter_aud_in      = 32'h0;
    filter_aud_out_rtr = 1'b1;

    // Reset
    repeat (3) cyc();
    rstb = 1'b0;
    check("rst_in_rtr",  filter_aud_in_rtr,  1'b1);
    check("rst_out_rts", filter_aud_out_rts, 1'b0);
    check("rst_load",    accumulator_load,   1'b0);
    check("rst_en",      accumulator_enable, 1'b0);
    check("rst_re",      mux_re,             1'b0);
    check("rst_acc_l",   accumulator_in_left,  0);
    check("rst_acc_r",   accumulator_in_right, 0);
    cyc();

    // Impulse walks through the taps, picking up c[n] = n+1
    for (int n = 0; n < NTAPS; n++) begin
      send((n == 0) ? 32'h0001_FFFF : 32'h0);
      check_impulse(n, "imp");
      finish_out();
    end

    // Backpressure with a pending input
    filter_aud_out_rtr = 1'b0;
    send(32'h1234_5678);
    filter_aud_in_rts = 1'b1;
    filter_aud_in     = 32'h1111_2222;
    for (int i = 0; i < 10; i++) begin
      cyc();
      check("bp_out_rts", filter_aud_out_rts, 1'b1);
      check("bp_in_rtr",  filter_aud_in_rtr,  1'b0);
    end
    filter_aud_out_rtr = 1'b1;
    cyc();
    check("bp_idle_rts", filter_aud_out_rts, 1'b0);
    check("bp_idle_rtr", filter_aud_in_rtr,  1'b1);
    cyc();
    filter_aud_in_rts = 1'b0;
    run_mac();
    finish_out();

    // Arithmetic extremes
    for (int k = 0; k < NTAPS; k++) coef_tab[k] = 16'h8000;
    send(32'h8000_7FFF);
    check("ext_left",  cap_l[0], 32'h4000_0000);
    check("ext_right", cap_r[0], 32'hC000_8000);
    finish_out();

    // Reset in the middle of the MAC sweep
    for (int k = 0; k < NTAPS; k++) coef_tab[k] = 16'(k + 1);
    filter_aud_in_rts = 1'b1;
    filter_aud_in     = 32'h0003_0004;
    cyc();
    filter_aud_in_rts = 1'b0;
    repeat (6) cyc();
    check("mid_k5_en", accumulator_enable, 1'b1);
    rstb = 1'b1;
    cyc();
    rstb = 1'b0;
    check("mid_rst_rtr",  filter_aud_in_rtr,  1'b1);
    check("mid_rst_re",   mux_re,             1'b0);
    check("mid_rst_strb", {accumulator_load, accumulator_enable}, 0);
    check("mid_rst_orts", filter_aud_out_rts, 1'b0);
    check("mid_rst_accl", accumulator_in_left, 0);
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("mid_quiet_strb", {accumulator_load, accumulator_enable}, 0);
      check("mid_quiet_rtr",  filter_aud_in_rtr, 1'b1);
    end
    send(32'h0001_FFFF);
    check_impulse(0, "clr");
    finish_out();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fir_filter_stm.md
Name: fir_filter_stm

Overview:
Control and datapath-front block for a stereo FIR filter. It accepts 32-bit stereo audio words (left/right 16-bit signed) over an rts/rtr handshake and keeps a tap-delay line. For each accepted sample it sequences coefficient reads from the register-file mux, forms signed sample×coefficient products, and drives an external 40-bit accumulator through load/enable strobes. When the accumulation finishes, it signals output-ready to the downstream stage.

Parameters:
NTAPS, 16, number of filter taps (2..256).
ADDR_W, 4, width of mux_rdptr; must satisfy 2^ADDR_W >= NTAPS.

Ports:
clk  input  1  system clock; all logic on rising edge
rstb  input  1  synchronous reset, active-high (despite name)
filter_aud_in_rts  input  1  upstream has valid sample
filter_aud_in_rtr  output  1  block ready to accept a sample
filter_aud_in  input  32  [31:16] left, [15:0] right, signed two's complement
filter_aud_out_rts  output  1  accumulator result valid for downstream
filter_aud_out_rtr  input  1  downstream accepts result
accumulator_load  output  1  accumulator := accumulator_in (first tap)
accumulator_enable  output  1  accumulator += accumulator_in (later taps)
accumulator_in_left  output  32  signed product, left channel
accumulator_in_right  output  32  signed product, right channel
rf_filter_coeff  input  16  signed coefficient; valid the cycle after a mux_re request
mux_re  output  1  coefficient read enable
mux_rdptr  output  ADDR_W  coefficient index to read

Behaviour:
- Reset (rstb=1 at a clock edge): state IDLE; delay line x[0..NTAPS-1] cleared to 0; tap counter 0. All outputs 0 except filter_aud_in_rtr=1. Reset overrides any state, including mid-MAC and OUT.
- States: IDLE, FETCH, MAC, OUT.
- IDLE: filter_aud_in_rtr=1. Transfer happens when rts&rtr at an edge: shift the delay line (x[k]<=x[k-1], x[0]<=filter_aud_in); next state FETCH. rts low: stay in IDLE.
- FETCH (1 cycle): mux_re=1, mux_rdptr=0; rtr=0; next state MAC, k=0.
- MAC (NTAPS cycles, k=0..NTAPS-1):
  - accumulator_in_left = signed(x[k][31:16]) × signed(rf_filter_coeff), full 32-bit.
  - accumulator_in_right = signed(x[k][15:0]) × signed(rf_filter_coeff), full 32-bit.
  - These are combinational from the delay line and coefficient; they are 0 outside MAC.
  - k=0: accumulator_load=1, accumulator_enable=0. k>0: accumulator_enable=1, accumulator_load=0. load and enable are never both high.
  - Pipelined read: mux_re=1 with mux_rdptr=k+1 when k<NTAPS-1; mux_re=0 on the last tap.
  - After k=NTAPS-1, go to OUT.
- OUT: filter_aud_out_rts=1, held until filter_aud_out_rtr=1 at an edge, then IDLE. No new input is accepted in OUT (rtr=0).
- Latency: transfer edge at cycle T; FETCH at T+1; taps at T+2..T+1+NTAPS; out_rts first high at T+2+NTAPS.
- Minimum period with out_rtr tied high: NTAPS+3 cycles per sample.
- Each sample uses coefficients c[0..NTAPS-1] in that order. x[0] is the newest sample.
- mux_rdptr is 0 whenever mux_re=0.
- The delay line shifts only on an accepted transfer. The external accumulator result is not reset by this block.

Test Plan:
- Reset: hold rstb=1 for 3 cycles, then release → in_rtr=1; out_rts, load, enable and mux_re are all 0; accumulator_in_* = 0.
- Impulse, NTAPS=16, c[k]=k+1: send 0x0001_FFFF, then zeros. On the first sample, tap k=0 shows left=1, right=-1 with load=1. On the n-th subsequent sample, tap k=n shows left=n+1, right=-(n+1); all other taps show 0.
- Read sequencing: after a transfer, mux_rdptr goes 0,1,…,15 on consecutive cycles with mux_re=1, then mux_re drops. Check: load pulses exactly once, enable is high for exactly 15 cycles, and out_rts rises 18 cycles after the transfer edge.
- Backpressure: hold filter_aud_out_rtr=0 for 10 cycles → out_rts stays 1 and in_rtr stays 0. Raise rtr → IDLE on the next cycle; a pending in_rts is accepted the cycle after.
- Arithmetic extremes: sample 0x8000_7FFF with c=0x8000 → left=0x4000_0000, right=0xC000_8000.
- Reset mid-MAC (at k=5) → next cycle state is IDLE, in_rtr=1, delay line zeroed, no further load/enable pulses.
